// File: rtl/skip_nxm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : skip_nxm
// Purpose  : Runtime N x M decimator for an RGB video stream (vs/hs/de + RGB).
//            Keeps one pixel of every N per line and one line of every M per
//            frame by gating de_o. Syncs and pixel data pass through with a
//            fixed one-clock latency. Configuration is sampled at frame start.
// Options  : define SKIP_NXM_PHASE_EN to add h_phase_i / v_phase_i, which
//            select the kept pixel/line inside each group (default: first).
// Revision : 1.0 - initial release
// ============================================================================
module skip_nxm #(
  parameter int DATA_W = 8,
  parameter int FACT_W = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  // incoming video
  input  logic              vs_i,
  input  logic              hs_i,
  input  logic              de_i,
  input  logic [DATA_W-1:0] rgb_r_i,
  input  logic [DATA_W-1:0] rgb_g_i,
  input  logic [DATA_W-1:0] rgb_b_i,
  // configuration, sampled at frame start
  input  logic              enable_i,
  input  logic [FACT_W-1:0] h_factor_i,
  input  logic [FACT_W-1:0] v_factor_i,
`ifdef SKIP_NXM_PHASE_EN
  input  logic [FACT_W-1:0] h_phase_i,
  input  logic [FACT_W-1:0] v_phase_i,
`endif
  // outgoing video
  output logic              vs_o,
  output logic              hs_o,
  output logic              de_o,
  output logic [DATA_W-1:0] rgb_r_o,
  output logic [DATA_W-1:0] rgb_g_o,
  output logic [DATA_W-1:0] rgb_b_o
);

  localparam logic [FACT_W-1:0] CNT_ONE = FACT_W'(1);

  // one-clock delayed copies used for edge detection
  logic              vs_d0;
  logic              de_d0;

  // configuration latched at frame start
  logic              en_lat;
  logic [FACT_W-1:0] hf_lat;
  logic [FACT_W-1:0] vf_lat;

  // position counters within the current group
  logic [FACT_W-1:0] h_cnt;
  logic [FACT_W-1:0] v_cnt;

  // edge events
  logic              fs;
  logic              ls;
  logic              le;

  // configuration in force for the current input cycle
  logic              en_eff;
  logic [FACT_W-1:0] hf_eff;
  logic [FACT_W-1:0] vf_eff;
  logic [FACT_W-1:0] hp_eff;
  logic [FACT_W-1:0] vp_eff;

  // counter values applied to the current pixel, and next-state values
  logic [FACT_W-1:0] h_use;
  logic [FACT_W-1:0] v_use;
  logic [FACT_W-1:0] h_nxt;
  logic [FACT_W-1:0] v_nxt;
  logic              keep;

  assign fs = vs_i & ~vs_d0;
  assign ls = de_i & ~de_d0;
  assign le = de_d0 & ~de_i;

  // The frame-start cycle already uses the new configuration, so the live
  // inputs are selected in that cycle instead of the (still old) latches.
  assign en_eff = fs ? enable_i   : en_lat;
  assign hf_eff = fs ? h_factor_i : hf_lat;
  assign vf_eff = fs ? v_factor_i : vf_lat;

`ifdef SKIP_NXM_PHASE_EN
  logic [FACT_W-1:0] hp_lat;
  logic [FACT_W-1:0] vp_lat;
  logic [FACT_W-1:0] hp_raw;
  logic [FACT_W-1:0] vp_raw;

  assign hp_raw = fs ? h_phase_i : hp_lat;
  assign vp_raw = fs ? v_phase_i : vp_lat;
  // A phase beyond the group size selects the last member of the group.
  assign hp_eff = (hp_raw > hf_eff) ? hf_eff : hp_raw;
  assign vp_eff = (vp_raw > vf_eff) ? vf_eff : vp_raw;

  // phase registers follow the same frame-start sampling as the factors
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hp_lat <= '0;
      vp_lat <= '0;
    end else if (fs) begin
      hp_lat <= h_phase_i;
      vp_lat <= v_phase_i;
    end
  end
`else
  assign hp_eff = '0;
  assign vp_eff = '0;
`endif

  // A line start always restarts the pixel group so no partial group carries
  // over between lines; a frame start likewise restarts the line group.
  assign h_use = ls ? '0 : h_cnt;
  assign v_use = fs ? '0 : v_cnt;

  // ">=" rather than "==" keeps the counter bounded even if it ever holds a
  // value above the factor in force.
  assign h_nxt = !de_i ? h_cnt :
                 (h_use >= hf_eff) ? '0 : (h_use + CNT_ONE);
  assign v_nxt = fs ? '0 :
                 !le ? v_cnt :
                 (v_cnt >= vf_eff) ? '0 : (v_cnt + CNT_ONE);

  assign keep = ~en_eff | ((h_use == hp_eff) & (v_use == vp_eff));

  // sample configuration once per frame so mid-frame changes have no effect
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      en_lat <= 1'b0;
      hf_lat <= '0;
      vf_lat <= '0;
    end else if (fs) begin
      en_lat <= enable_i;
      hf_lat <= h_factor_i;
      vf_lat <= v_factor_i;
    end
  end

  // advance the horizontal and vertical group position counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  // one-clock video pipeline; only de_o is gated by the keep decision
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vs_d0   <= 1'b0;
      de_d0   <= 1'b0;
      vs_o    <= 1'b0;
      hs_o    <= 1'b0;
      de_o    <= 1'b0;
      rgb_r_o <= '0;
      rgb_g_o <= '0;
      rgb_b_o <= '0;
    end else begin
      vs_d0   <= vs_i;
      de_d0   <= de_i;
      vs_o    <= vs_i;
      hs_o    <= hs_i;
      de_o    <= de_i & keep;
      rgb_r_o <= rgb_r_i;
      rgb_g_o <= rgb_g_i;
      rgb_b_o <= rgb_b_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_skip_nxm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_skip_nxm
// Purpose  : Scoreboard bench for skip_nxm. The stimulus process drives one
//            video cycle per clock and queues the output expected one clock
//            later; a monitor process pops and compares every cycle, and
//            counts de_o pulses for per-frame totals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_skip_nxm;

  typedef struct packed {
    logic       vs;
    logic       hs;
    logic       de;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       vs_i, hs_i, de_i;
  logic [7:0] rgb_r_i, rgb_g_i, rgb_b_i;
  logic       enable_i;
  logic [2:0] h_factor_i, v_factor_i;
`ifdef SKIP_NXM_PHASE_EN
  logic [2:0] h_phase_i, v_phase_i;
`endif
  logic       vs_o, hs_o, de_o;
  logic [7:0] rgb_r_o, rgb_g_o, rgb_b_o;

  int   checks = 0;
  int   errors = 0;
  int   de_seen = 0;
  vec_t exp_q[$];

  skip_nxm #(.DATA_W(8), .FACT_W(3)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .vs_i       (vs_i),
    .hs_i       (hs_i),
    .de_i       (de_i),
    .rgb_r_i    (rgb_r_i),
    .rgb_g_i    (rgb_g_i),
    .rgb_b_i    (rgb_b_i),
    .enable_i   (enable_i),
    .h_factor_i (h_factor_i),
    .v_factor_i (v_factor_i),
`ifdef SKIP_NXM_PHASE_EN
    .h_phase_i  (h_phase_i),
    .v_phase_i  (v_phase_i),
`endif
    .vs_o       (vs_o),
    .hs_o       (hs_o),
    .de_o       (de_o),
    .rgb_r_o    (rgb_r_o),
    .rgb_g_o    (rgb_g_o),
    .rgb_b_o    (rgb_b_o)
  );

  always #5 clock = ~clock;

  function automatic vec_t dut_out();
    vec_t v;
    v.vs = vs_o; v.hs = hs_o; v.de = de_o;
    v.r = rgb_r_o; v.g = rgb_g_o; v.b = rgb_b_o;
    return v;
  endfunction

  task automatic compare(input string name, input vec_t got, input vec_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got vs=%b hs=%b de=%b rgb=%h/%h/%h, expected vs=%b hs=%b de=%b rgb=%h/%h/%h",
               name, $time, got.vs, got.hs, got.de, got.r, got.g, got.b,
               exp.vs, exp.hs, exp.de, exp.r, exp.g, exp.b);
    end
  endtask

  // Monitor: every cycle with a queued expectation is compared one clock
  // after its stimulus was applied.
  initial begin
    vec_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (de_o === 1'b1) de_seen++;
        compare("out_vec", dut_out(), e);
      end
    end
  end

  // Drive one input cycle at the falling edge and queue its expected output.
  task automatic drive(input logic rst_low, input logic v, h, d,
                       input logic [7:0] r, g, b, input logic kept);
    vec_t e;
    @(negedge clock);
    reset_n = ~rst_low;
    vs_i = v; hs_i = h; de_i = d;
    rgb_r_i = r; rgb_g_i = g; rgb_b_i = b;
    if (rst_low) begin
      e = '0;
      #1;
      compare("async_reset", dut_out(), '0);
    end else begin
      e.vs = v; e.hs = h; e.de = d & kept;
      e.r = r; e.g = g; e.b = b;
    end
    exp_q.push_back(e);
  endtask

  // One frame: 2 vs cycles, 2 blank cycles, then per line an hs cycle, a
  // blank cycle, the active pixels and a blank cycle, then 2 trailing blanks.
  // chg_line >= 0 rewrites h_factor_i at that line; rst_line >= 0 pulses
  // reset for 3 pixel cycles starting at rst_pix of that line.
  task automatic run_frame(input string name, input logic en,
                           input int hf, vf, hp, vp, nlines, npix,
                           input int chg_line, chg_hf, rst_line, rst_pix,
                           input int exp_kept);
    int         start;
    logic       m_en;
    int         m_hf, m_vf, m_hp, m_vp;
    logic [7:0] r;
    logic       kept;
    start = de_seen;
    enable_i = en;
    h_factor_i = 3'(hf);
    v_factor_i = 3'(vf);
    m_en = en; m_hf = hf; m_vf = vf;
`ifdef SKIP_NXM_PHASE_EN
    h_phase_i = 3'(hp);
    v_phase_i = 3'(vp);
    m_hp = (hp > hf) ? hf : hp;
    m_vp = (vp > vf) ? vf : vp;
`else
    m_hp = 0; m_vp = 0;
    if (hp != 0 || vp != 0) $display("note: phase ignored in this build");
`endif
    drive(0, 1, 0, 0, 8'h11, 8'h22, 8'h33, 1'b0);
    drive(0, 1, 0, 0, 8'h12, 8'h23, 8'h34, 1'b0);
    drive(0, 0, 0, 0, 8'h13, 8'h24, 8'h35, 1'b0);
    drive(0, 0, 0, 0, 8'h14, 8'h25, 8'h36, 1'b0);
    for (int l = 0; l < nlines; l++) begin
      drive(0, 0, 1, 0, 8'hA5, 8'h5A, 8'hC3, 1'b0);
      drive(0, 0, 0, 0, 8'h3C, 8'h96, 8'h69, 1'b0);
      for (int p = 0; p < npix; p++) begin
        if (l == chg_line && p == 0) h_factor_i = 3'(chg_hf);
        r = 8'(l * 16 + p);
        if (l == rst_line && p >= rst_pix && p < rst_pix + 3) begin
          drive(1, 0, 0, 1, r, ~r, 8'(p * 7 + l), 1'b0);
          m_en = 1'b0;
        end else begin
          kept = !m_en || (((p % (m_hf + 1)) == m_hp) &&
                           ((l % (m_vf + 1)) == m_vp));
          drive(0, 0, 0, 1, r, ~r, 8'(p * 7 + l), kept);
        end
      end
      drive(0, 0, 0, 0, 8'h77, 8'h88, 8'h99, 1'b0);
    end
    drive(0, 0, 0, 0, 8'h01, 8'h02, 8'h03, 1'b0);
    drive(0, 0, 0, 0, 8'h04, 8'h05, 8'h06, 1'b0);
    @(posedge clock);
    #2;
    checks++;
    if (de_seen - start != exp_kept) begin
      errors++;
      $display("FAIL kept_count %s: got %0d de_o pulses, expected %0d",
               name, de_seen - start, exp_kept);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    vs_i = 1'b1; hs_i = 1'b1; de_i = 1'b1;
    rgb_r_i = 8'hFF; rgb_g_i = 8'hEE; rgb_b_i = 8'hDD;
    enable_i = 1'b1; h_factor_i = 3'd1; v_factor_i = 3'd1;
`ifdef SKIP_NXM_PHASE_EN
    h_phase_i = 3'd0; v_phase_i = 3'd0;
`endif
    repeat (3) @(posedge clock);
    @(negedge clock);
    compare("reset_state", dut_out(), '0);

    // bypass: every pixel of every line
    run_frame("bypass", 1'b0, 0, 0, 0, 0, 8, 16, -1, 0, -1, 0, 128);
    // 2x1: even pixels, all lines
    run_frame("h2v1", 1'b1, 1, 0, 0, 0, 8, 16, -1, 0, -1, 0, 64);
    // 3x2 with 10-pixel lines: pixels 0,3,6,9 on even lines
    run_frame("h3v2_odd", 1'b1, 2, 1, 0, 0, 8, 10, -1, 0, -1, 0, 16);
    // factor change at line 4 is ignored for the rest of this frame
    run_frame("midchg_a", 1'b1, 1, 0, 0, 0, 8, 16, 4, 3, -1, 0, 64);
    // next frame picks up 1-of-4
    run_frame("midchg_b", 1'b1, 3, 0, 0, 0, 8, 16, -1, 0, -1, 0, 32);
    // reset at line 3 pixel 5: 24 + 3 before, 8 + 64 bypassed after
    run_frame("reset_mid", 1'b1, 1, 0, 0, 0, 8, 16, -1, 0, 3, 5, 99);
    // decimation resumes from line 0 on the following frame
    run_frame("after_rst", 1'b1, 1, 0, 0, 0, 8, 16, -1, 0, -1, 0, 64);
    // both factor fields 0 with enable set behaves as bypass
    run_frame("h1v1_en", 1'b1, 0, 0, 0, 0, 4, 12, -1, 0, -1, 0, 48);
`ifdef SKIP_NXM_PHASE_EN
    // pixels 2,6,10,14 on lines 1,3,5,7
    run_frame("phase", 1'b1, 3, 1, 2, 1, 8, 16, -1, 0, -1, 0, 16);
    // phase 7 clamps to 3: pixels 3,7,11,15
    run_frame("phase_clamp", 1'b1, 3, 1, 7, 1, 8, 16, -1, 0, -1, 0, 16);
`endif

    repeat (2) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
